// File: rtl/klotski_motor_driver.sv
// Purpose : executes one 15-puzzle tile move on an X/Y stepper gantry with an electromagnet
//           (travel to source, grab, carry to destination, release, pulse done).
// Latency : done in cycle 1 + (2*STEP_HALF*d1 + 1) + SETTLE + (2*STEP_HALF*d2 + 1) + SETTLE after i_en.
// Backpressure: none; i_en is only accepted while idle (busy low), requests while busy are dropped.
// Ports   : i_clk, i_rst_n (async, active-low); i_en/i_start_block/i_end_block move request;
//           o_busy, o_done status; o_step_x/y, o_dir_x/y stepper drive; o_magnet; o_pos_x/y head position.
module klotski_motor_driver #(
  parameter int STEPS_PER_CELL = 200,
  parameter int STEP_HALF      = 2500,
  parameter int SETTLE_CYCLES  = 500000,
  parameter int POS_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [3:0]       i_start_block,
  input  logic [3:0]       i_end_block,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_step_x,
  output logic             o_step_y,
  output logic             o_dir_x,
  output logic             o_dir_y,
  output logic             o_magnet,
  output logic [POS_W-1:0] o_pos_x,
  output logic [POS_W-1:0] o_pos_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_GOTO_SRC, S_GRAB, S_CARRY, S_RELEASE, S_DONE
  } state_t;

  localparam int CW = $clog2(2 * STEP_HALF);
  localparam int WW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]    HI_START    = CW'(STEP_HALF - 1);
  localparam logic [CW-1:0]    PH_LAST     = CW'(2 * STEP_HALF - 1);
  localparam logic [WW-1:0]    SETTLE_LAST = WW'(SETTLE_CYCLES - 1);
  localparam logic [POS_W-1:0] SPC         = POS_W'(STEPS_PER_CELL);

  state_t           state, state_next;
  logic [POS_W-1:0] tgt_x, tgt_y;
  logic [3:0]       end_blk;
  logic             stepping;   // a step (low + high phase) is in progress
  logic             step_on_y;  // axis of the step in progress
  logic [CW-1:0]    ph_cnt;     // cycle index within the current step, 0 = evaluation cycle
  logic [WW-1:0]    wait_cnt;
  logic             motion, move_x, move_y;

  function automatic logic [POS_W-1:0] cell_coord(input logic [1:0] c);
    return POS_W'(c) * SPC;
  endfunction

  assign motion   = (state == S_GOTO_SRC) || (state == S_CARRY);
  assign move_x   = (o_pos_x != tgt_x);
  assign move_y   = (o_pos_y != tgt_y);

  // Status outputs are pure decodes of the state register so reset clears them at once.
  assign o_busy   = (state != S_IDLE);
  assign o_done   = (state == S_DONE);
  assign o_magnet = (state == S_GRAB) || (state == S_CARRY);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (i_en) state_next = S_GOTO_SRC;
      S_GOTO_SRC: if (!stepping && !move_x && !move_y) state_next = S_GRAB;
      S_GRAB:     if (wait_cnt == SETTLE_LAST) state_next = S_CARRY;
      S_CARRY:    if (!stepping && !move_x && !move_y) state_next = S_RELEASE;
      S_RELEASE:  if (wait_cnt == SETTLE_LAST) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tgt_x     <= '0;
      tgt_y     <= '0;
      end_blk   <= '0;
      stepping  <= 1'b0;
      step_on_y <= 1'b0;
      ph_cnt    <= '0;
      wait_cnt  <= '0;
      o_step_x  <= 1'b0;
      o_step_y  <= 1'b0;
      o_dir_x   <= 1'b0;
      o_dir_y   <= 1'b0;
      o_pos_x   <= '0;
      o_pos_y   <= '0;
    end else begin
      if (state == S_IDLE && i_en) begin
        tgt_x   <= cell_coord(i_start_block[1:0]);
        tgt_y   <= cell_coord(i_start_block[3:2]);
        end_blk <= i_end_block;
      end
      if (state == S_GRAB && state_next == S_CARRY) begin
        tgt_x <= cell_coord(end_blk[1:0]);
        tgt_y <= cell_coord(end_blk[3:2]);
      end

      // Settle counter runs only while dwelling in a magnet wait state.
      if ((state == S_GRAB || state == S_RELEASE) && state_next == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      if (motion) begin
        if (!stepping) begin
          // Evaluation cycle doubles as the first low-phase cycle of a new step.
          if (move_x || move_y) begin
            stepping  <= 1'b1;
            step_on_y <= !move_x;
            ph_cnt    <= CW'(1);
            if (move_x) o_dir_x <= (tgt_x > o_pos_x);
            else        o_dir_y <= (tgt_y > o_pos_y);
            if (HI_START == '0) begin
              if (move_x) o_step_x <= 1'b1;
              else        o_step_y <= 1'b1;
            end
          end
        end else begin
          ph_cnt <= ph_cnt + 1'b1;
          if (ph_cnt == HI_START) begin
            if (step_on_y) o_step_y <= 1'b1;
            else           o_step_x <= 1'b1;
          end
          if (ph_cnt == PH_LAST) begin
            stepping <= 1'b0;
            ph_cnt   <= '0;
            o_step_x <= 1'b0;
            o_step_y <= 1'b0;
            if (step_on_y) o_pos_y <= o_dir_y ? o_pos_y + 1'b1 : o_pos_y - 1'b1;
            else           o_pos_x <= o_dir_x ? o_pos_x + 1'b1 : o_pos_x - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_klotski_motor_driver.sv
// Purpose : self-checking bench for klotski_motor_driver against a per-cycle timeline model.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
module tb_klotski_motor_driver;

  localparam int SPC = 4;
  localparam int SH  = 2;
  localparam int ST  = 3;
  localparam int PW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic [3:0]    sb = '0, eb = '0;
  logic          busy, done, step_x, step_y, dir_x, dir_y, magnet;
  logic [PW-1:0] pos_x, pos_y;

  always #5 clk = ~clk;

  klotski_motor_driver #(
    .STEPS_PER_CELL(SPC), .STEP_HALF(SH), .SETTLE_CYCLES(ST), .POS_W(PW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start_block(sb), .i_end_block(eb),
    .o_busy(busy), .o_done(done), .o_step_x(step_x), .o_step_y(step_y),
    .o_dir_x(dir_x), .o_dir_y(dir_y), .o_magnet(magnet), .o_pos_x(pos_x), .o_pos_y(pos_y)
  );

  // One expected output snapshot for one absolute cycle.
  typedef struct {
    int cyc;
    bit busy, done, mag, sx, sy, dchk_x, dchk_y, dx, dy;
    int px, py;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  int   cyc = 0;
  int   tests = 0, fails = 0;
  bit   chk_en = 1'b0;
  int   mx = 0, my = 0;          // model head position after all queued work
  int   last_x = 0, last_y = 0;  // position expected while idle

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, act, expv);
    end
  endtask

  task automatic push_e(input int c, input bit mag, input bit dn, input bit sx, input bit sy, input bit d);
    exp_t e;
    e.cyc = c; e.busy = 1'b1; e.done = dn; e.mag = mag;
    e.sx = sx; e.sy = sy; e.dchk_x = sx; e.dchk_y = sy; e.dx = d; e.dy = d;
    e.px = mx; e.py = my;
    q.push_back(e);
  endtask

  // Straight-line travel: all X steps, then all Y steps, then one arrival cycle.
  task automatic travel(inout int c, input int tx, input int ty, input bit mag);
    while (mx != tx) begin
      bit d;
      d = (tx > mx);
      for (int k = 0; k < 2 * SH; k++) begin push_e(c, mag, 1'b0, k >= SH, 1'b0, d); c++; end
      mx += d ? 1 : -1;
    end
    while (my != ty) begin
      bit d;
      d = (ty > my);
      for (int k = 0; k < 2 * SH; k++) begin push_e(c, mag, 1'b0, 1'b0, k >= SH, d); c++; end
      my += d ? 1 : -1;
    end
    push_e(c, mag, 1'b0, 1'b0, 1'b0, 1'b0); c++;
  endtask

  task automatic gen_move(input logic [3:0] s, input logic [3:0] e, input int c0);
    int c;
    c = c0 + 1;
    travel(c, int'(s[1:0]) * SPC, int'(s[3:2]) * SPC, 1'b0);
    repeat (ST) begin push_e(c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); c++; end
    travel(c, int'(e[1:0]) * SPC, int'(e[3:2]) * SPC, 1'b1);
    repeat (ST) begin push_e(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); c++; end
    push_e(c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Single compare process: every cycle, against the timeline or the idle expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      ce.cyc = cyc; ce.busy = 0; ce.done = 0; ce.mag = 0; ce.sx = 0; ce.sy = 0;
      ce.dchk_x = 0; ce.dchk_y = 0; ce.dx = 0; ce.dy = 0; ce.px = last_x; ce.py = last_y;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ce = q.pop_front();
        last_x = ce.px;
        last_y = ce.py;
      end
      tests++;
      if (busy !== ce.busy || done !== ce.done || magnet !== ce.mag ||
          step_x !== ce.sx || step_y !== ce.sy ||
          (ce.dchk_x && dir_x !== ce.dx) || (ce.dchk_y && dir_y !== ce.dy) ||
          int'(pos_x) != ce.px || int'(pos_y) != ce.py) begin
        fails++;
        $display("FAIL cycle_check cyc=%0d got busy=%b done=%b mag=%b sx=%b sy=%b dx=%b dy=%b px=%0d py=%0d want busy=%b done=%b mag=%b sx=%b sy=%b dx=%b dy=%b px=%0d py=%0d",
                 cyc, busy, done, magnet, step_x, step_y, dir_x, dir_y, pos_x, pos_y,
                 ce.busy, ce.done, ce.mag, ce.sx, ce.sy, ce.dx, ce.dy, ce.px, ce.py);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, "_busy"},   busy,   0);
    chk({tag, "_done"},   done,   0);
    chk({tag, "_step_x"}, step_x, 0);
    chk({tag, "_step_y"}, step_y, 0);
    chk({tag, "_dir_x"},  dir_x,  0);
    chk({tag, "_dir_y"},  dir_y,  0);
    chk({tag, "_magnet"}, magnet, 0);
    chk({tag, "_pos_x"},  int'(pos_x), 0);
    chk({tag, "_pos_y"},  int'(pos_y), 0);
    q.delete();
    mx = 0; my = 0; last_x = 0; last_y = 0;
    step();
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  // Issue one move; inj = cycle offset of a forced busy-time request (-1 none); noise adds random ones.
  task automatic do_move(input logic [3:0] s, input logic [3:0] e, input int inj, input bit noise,
                         output int off);
    int c0;
    c0 = cyc;
    en = 1'b1; sb = s; eb = e;
    gen_move(s, e, c0);
    off = q[$].cyc - c0;
    step();
    en = 1'b0;
    for (int i = 1; i < off; i++) begin
      if (i == inj || (noise && $urandom_range(0, 7) == 0)) begin
        en = 1'b1;
        sb = (i == inj) ? 4'hF : 4'($urandom);
        eb = 4'($urandom);
      end
      step();
      en = 1'b0;
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int off;
    int c0;
    step();
    do_reset("rst");

    // Adjacent move from the head cell.
    do_move(4'b0000, 4'b0001, -1, 1'b0, off);
    chk("s2_done_cycle", off, 25);
    chk("s2_pos_x", int'(pos_x), 4);
    chk("s2_pos_y", int'(pos_y), 0);

    // Travel then carry, back to back.
    do_move(4'b0110, 4'b0010, -1, 1'b0, off);
    chk("s3_done_cycle", off, 57);
    chk("s3_pos_x", int'(pos_x), 8);
    chk("s3_pos_y", int'(pos_y), 0);

    // Request while busy is dropped.
    do_reset("s4rst");
    do_move(4'b0000, 4'b0001, 10, 1'b0, off);
    chk("s4_done_cycle", off, 25);
    chk("s4_pos_x", int'(pos_x), 4);

    // Reset during the high phase of the second carry step.
    do_reset("s5pre");
    c0 = cyc;
    en = 1'b1; sb = 4'b0000; eb = 4'b0001;
    gen_move(4'b0000, 4'b0001, c0);
    step();
    en = 1'b0;
    repeat (10) step();
    chk("s5_step_x_before", step_x, 1);
    chk("s5_magnet_before", magnet, 1);
    chk("s5_pos_x_before", int'(pos_x), 1);
    do_reset("s5rst");
    repeat (30) step();

    // Zero-length move still grabs and releases.
    do_move(4'b0000, 4'b0000, -1, 1'b0, off);
    chk("s6_done_cycle", off, 9);

    // Random moves with random gaps and ignored requests while busy.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] s, e;
      s = 4'($urandom);
      e = 4'($urandom);
      repeat ($urandom_range(0, 3)) step();
      do_move(s, e, -1, 1'b1, off);
    end
    repeat (5) step();
    chk("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
